ntt_vec_sequencer: RTL and testbench

- Parametrised successor to the single-poly NTT wrapper. It sequences a vector of up to VEC_K polynomials through an external NTT/PWM core, one polynomial at a time.
- It streams operands into the core LANES coefficients per cycle, issues the start pulse, waits for the core's done, reads the result back and presents it as a full polynomial.
- Sits between the linear-operation FSM and the NTT core. It replaces the per-poly wrapper plus the k-counter logic.

---
 rtl/ntt_vec_sequencer_if.sv | 26 ++
 rtl/ntt_vec_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_ntt_vec_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_vec_sequencer_if.sv
// ntt_vec_sequencer_if: link between the vector sequencer and the NTT/PWM core.
// master = sequencer (load/start/read pulses, operand beats); slave = core (result beats, done).
interface ntt_vec_sequencer_if #(
    parameter int COEF_W = 12,
    parameter int LANES  = 1
);
    logic                      core_load_a_o;
    logic                      core_load_b_o;
    logic [2:0]                core_start_o;
    logic                      core_read_o;
    logic [LANES*COEF_W-1:0]   core_din_o;
    logic [LANES*COEF_W-1:0]   core_dout_i;
    logic                      core_done_i;

    modport master (
        output core_load_a_o, core_load_b_o, core_start_o,
        output core_read_o, core_din_o,
        input  core_dout_i, core_done_i
    );

    modport slave (
        input  core_load_a_o, core_load_b_o, core_start_o,
        input  core_read_o, core_din_o,
        output core_dout_i, core_done_i
    );
endinterface

// File: rtl/ntt_vec_sequencer.sv
// ntt_vec_sequencer: streams up to VEC_K polys through an NTT/PWM core one at a time.
// Ports: clk_i/rst_n_i, run_i/mode_i/vec_len_i/acc_i request, poly_idx_o selects
// poly_a_i/poly_b_i, core (master modport) to the core, poly_c_o/poly_valid_o
// result, busy_o/done_o/err_o status. Optional macro ACC_EN adds a mod-Q accumulator.
module ntt_vec_sequencer #(
    parameter int COEF_W   = 12,
    parameter int N        = 256,
    parameter int LANES    = 1,
    parameter int VEC_K    = 4,
    parameter int READ_LAT = 1,
    parameter int Q        = 3329,
    localparam int KW      = (VEC_K > 1) ? $clog2(VEC_K) : 1,
    localparam int LENW    = $clog2(VEC_K + 1),
    localparam int PW      = N * COEF_W,
    localparam int LW      = LANES * COEF_W
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            run_i,
    input  logic [1:0]      mode_i,
    input  logic [LENW-1:0] vec_len_i,
    input  logic            acc_i,
    output logic [KW-1:0]   poly_idx_o,
    input  logic [PW-1:0]   poly_a_i,
    input  logic [PW-1:0]   poly_b_i,
    ntt_vec_sequencer_if.master core,
    output logic [PW-1:0]   poly_c_o,
    output logic            poly_valid_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);
    localparam int NB = N / LANES;
    localparam int CW = $clog2(NB + READ_LAT + 1);
    localparam logic [CW-1:0] C_BEATS = CW'(NB);
    localparam logic [CW-1:0] C_RLAT  = CW'(READ_LAT);
    localparam logic [CW-1:0] C_RLAST = CW'(READ_LAT + NB - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_START,
        S_WAIT, S_READ, S_EMIT, S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [KW-1:0]   r_k;
    logic [1:0]      r_mode;
    logic [LENW-1:0] r_len;
    logic [PW-1:0]   r_sh;
    logic [PW-1:0]   r_res;
    logic [PW-1:0]   r_c;
    logic [LW-1:0]   r_din;
    logic            r_load_a;
    logic            r_load_b;
    logic [2:0]      r_start;
    logic            r_read;
    logic            r_valid;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic            w_bad;
    logic            w_last;
    logic [2:0]      w_start_oh;
    logic [PW-1:0]   w_op;
    logic [PW-1:0]   w_res_nx;
    logic            w_unused;

    assign w_bad = (mode_i == 2'b11) || (vec_len_i == '0)
                || (vec_len_i > LENW'(VEC_K));
    assign w_last = (LENW'(r_k) + LENW'(1)) == r_len;
    assign w_start_oh = (r_mode == 2'b01) ? 3'b100 :
                        (r_mode == 2'b10) ? 3'b010 : 3'b001;
    assign w_op = (r_state == S_LOAD_A) ? poly_a_i : poly_b_i;
    // Result beats enter at the top so beat 0 ends up in the low lanes.
    assign w_res_nx = {core.core_dout_i, r_res[PW-1:LW]};

`ifdef ACC_EN
    localparam logic [COEF_W:0] C_Q = (COEF_W + 1)'(Q);

    logic          r_acc;
    logic [PW-1:0] r_accv;
    logic [PW-1:0] w_acc_nx;
    logic [LW-1:0] w_sum;

    function automatic logic [COEF_W-1:0] f_modadd(
        input logic [COEF_W-1:0] a,
        input logic [COEF_W-1:0] b
    );
        logic [COEF_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= C_Q) s = s - C_Q;
        return s[COEF_W-1:0];
    endfunction

    always_comb begin
        w_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_sum[l*COEF_W +: COEF_W] = f_modadd(
                r_accv[l*COEF_W +: COEF_W],
                core.core_dout_i[l*COEF_W +: COEF_W]);
        end
    end

    // The accumulator rotates one beat per read beat, so after a full
    // read it is back in coefficient order.
    assign w_acc_nx = {w_sum, r_accv[PW-1:LW]};
    assign w_unused = ^r_res[LW-1:0];
`else
    assign w_unused = ^{acc_i, r_res[LW-1:0], (Q == 0)};
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_k      <= '0;
            r_mode   <= '0;
            r_len    <= '0;
            r_sh     <= '0;
            r_res    <= '0;
            r_c      <= '0;
            r_din    <= '0;
            r_load_a <= 1'b0;
            r_load_b <= 1'b0;
            r_start  <= '0;
            r_read   <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
`ifdef ACC_EN
            r_acc    <= 1'b0;
            r_accv   <= '0;
`endif
        end else begin
            r_load_a <= 1'b0;
            r_load_b <= 1'b0;
            r_start  <= '0;
            r_read   <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (run_i) begin
                        if (w_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_mode   <= mode_i;
                            r_len    <= vec_len_i;
                            r_k      <= '0;
                            r_cnt    <= '0;
                            r_load_a <= 1'b1;
                            r_busy   <= 1'b1;
                            r_state  <= S_LOAD_A;
`ifdef ACC_EN
                            r_acc    <= acc_i;
                            r_accv   <= '0;
`endif
                        end
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == '0) begin
                        r_din <= w_op[LW-1:0];
                        r_sh  <= w_op >> LW;
                    end else if (r_cnt == C_BEATS) begin
                        r_din <= '0;
                        r_cnt <= '0;
                        if (r_state == S_LOAD_A && r_mode == 2'b10) begin
                            r_load_b <= 1'b1;
                            r_state  <= S_LOAD_B;
                        end else begin
                            r_start <= w_start_oh;
                            r_state <= S_START;
                        end
                    end else begin
                        r_din <= r_sh[LW-1:0];
                        r_sh  <= r_sh >> LW;
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core.core_done_i) begin
                        r_read  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt >= C_RLAT) begin
                        r_res <= w_res_nx;
`ifdef ACC_EN
                        if (r_acc) r_accv <= w_acc_nx;
`endif
                    end
                    if (r_cnt == C_RLAST) begin
                        r_cnt   <= '0;
                        r_state <= S_EMIT;
`ifdef ACC_EN
                        if (r_acc) begin
                            r_valid <= w_last;
                            if (w_last) r_c <= w_acc_nx;
                        end else begin
                            r_valid <= 1'b1;
                            r_c     <= w_res_nx;
                        end
`else
                        r_valid <= 1'b1;
                        r_c     <= w_res_nx;
`endif
                    end
                end
                S_EMIT: begin
                    r_cnt <= '0;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_k      <= r_k + KW'(1);
                        r_load_a <= 1'b1;
                        r_state  <= S_LOAD_A;
                    end
                end
                S_DONE: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign poly_idx_o         = r_k;
    assign poly_c_o           = r_c;
    assign poly_valid_o       = r_valid;
    assign busy_o             = r_busy;
    assign done_o             = r_done;
    assign err_o              = r_err;
    assign core.core_load_a_o = r_load_a;
    assign core.core_load_b_o = r_load_b;
    assign core.core_start_o  = r_start;
    assign core.core_read_o   = r_read;
    assign core.core_din_o    = r_din;
endmodule

// File: tb/tb_ntt_vec_sequencer.sv
// tb_ntt_vec_sequencer: directed bench, two sequencers (1 lane and 4 lanes)
// each driving a small behavioural NTT core model.
module tb_ntt_vec_sequencer;
    localparam int PW  = 3072;
    localparam int DLY = 10;
`ifdef ACC_EN
    localparam bit ACC_ON = 1'b1;
`else
    localparam bit ACC_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run1 = 1'b0;
    logic          run4 = 1'b0;
    logic [1:0]    mode = '0;
    logic [2:0]    vlen = '0;
    logic          acc = 1'b0;
    logic [PW-1:0] pa1, pb1, pa4, pb4;
    logic [PW-1:0] pc1, pc4;
    logic [1:0]    idx1, idx4;
    logic          valid1, valid4, busy1, busy4;
    logic          done1, done4, err1, err4;

    int n_cmp = 0;
    int n_bad = 0;

    ntt_vec_sequencer_if #(.COEF_W(12), .LANES(1)) c1 ();
    ntt_vec_sequencer_if #(.COEF_W(12), .LANES(4)) c4 ();

    ntt_vec_sequencer #(.LANES(1)) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .run_i(run1),
        .mode_i(mode), .vec_len_i(vlen), .acc_i(acc),
        .poly_idx_o(idx1), .poly_a_i(pa1), .poly_b_i(pb1),
        .core(c1), .poly_c_o(pc1), .poly_valid_o(valid1),
        .busy_o(busy1), .done_o(done1), .err_o(err1)
    );

    ntt_vec_sequencer #(.LANES(4)) u4 (
        .clk_i(clk), .rst_n_i(rst_n), .run_i(run4),
        .mode_i(mode), .vec_len_i(vlen), .acc_i(acc),
        .poly_idx_o(idx4), .poly_a_i(pa4), .poly_b_i(pb4),
        .core(c4), .poly_c_o(pc4), .poly_valid_o(valid4),
        .busy_o(busy4), .done_o(done4), .err_o(err4)
    );

    always #5 clk = ~clk;

    function automatic int fa(int k, int j);
        return (k * 300 + j * 7 + 1) % 3329;
    endfunction

    function automatic int fb(int k, int j);
        return (k * 11 + j * 13 + 5) % 3329;
    endfunction

    always_comb begin
        pa1 = '0;
        pb1 = '0;
        pa4 = '0;
        pb4 = '0;
        for (int j = 0; j < 256; j++) begin
            pa1[j*12 +: 12] = 12'(fa(int'(idx1), j));
            pb1[j*12 +: 12] = 12'(fb(int'(idx1), j));
            pa4[j*12 +: 12] = 12'(fa(int'(idx4), j));
            pb4[j*12 +: 12] = 12'(fb(int'(idx4), j));
        end
    end

    // Core model: captures operand beats, raises done DLY cycles after
    // start, returns (a + b + start_code) mod 3329 with one cycle read latency.
    logic [11:0] ca [2][256];
    logic [11:0] cb [2][256];
    int la [2] = '{-1, -1};
    int lb [2] = '{-1, -1};
    int dc [2] = '{-1, -1};
    int rc [2] = '{-1, -1};
    int sv [2] = '{0, 0};
    int nba [2] = '{0, 0};
    int nbb [2] = '{0, 0};
    bit acc_mode = 1'b0;

    task automatic core_step(
        input int u, input int L,
        input logic ld_a, input logic ld_b,
        input logic [2:0] st, input logic rd,
        input logic [47:0] din,
        output logic [47:0] dout, output logic done
    );
        int nb;
        int j;
        nb = 256 / L;
        dout = '0;
        done = 1'b0;
        if (ld_a) begin
            la[u] = 0;
            for (int i = 0; i < 256; i++) cb[u][i] = '0;
        end else if (la[u] >= 0) begin
            la[u]++;
            if (la[u] <= nb) begin
                for (int l = 0; l < L; l++)
                    ca[u][(la[u]-1)*L+l] = din[l*12 +: 12];
                nba[u]++;
            end else la[u] = -1;
        end
        if (ld_b) lb[u] = 0;
        else if (lb[u] >= 0) begin
            lb[u]++;
            if (lb[u] <= nb) begin
                for (int l = 0; l < L; l++)
                    cb[u][(lb[u]-1)*L+l] = din[l*12 +: 12];
                nbb[u]++;
            end else lb[u] = -1;
        end
        if (st != 0) begin
            sv[u] = int'(st);
            dc[u] = 0;
        end else if (dc[u] >= 0) begin
            dc[u]++;
            if (dc[u] == DLY) done = 1'b1;
            if (dc[u] >= DLY) dc[u] = -1;
        end
        if (rd) rc[u] = 0;
        else if (rc[u] >= 0) begin
            rc[u]++;
            if (rc[u] <= nb) begin
                for (int l = 0; l < L; l++) begin
                    j = (rc[u] - 1) * L + l;
                    if (acc_mode) dout[l*12 +: 12] = 12'd3000;
                    else dout[l*12 +: 12] = 12'((int'(ca[u][j])
                        + int'(cb[u][j]) + sv[u]) % 3329);
                end
            end else rc[u] = -1;
        end
    endtask

    always @(negedge clk) begin
        logic [47:0] d;
        logic dn;
        core_step(0, 1, c1.core_load_a_o, c1.core_load_b_o,
            c1.core_start_o, c1.core_read_o,
            {36'b0, c1.core_din_o}, d, dn);
        c1.core_dout_i = d[11:0];
        c1.core_done_i = dn;
        core_step(1, 4, c4.core_load_a_o, c4.core_load_b_o,
            c4.core_start_o, c4.core_read_o,
            c4.core_din_o, d, dn);
        c4.core_dout_i = d;
        c4.core_done_i = dn;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int poly_bad(
        input logic [PW-1:0] pc, input int k,
        input logic [1:0] md, input bit accm, input int len
    );
        int n;
        int e;
        int off;
        n = 0;
        off = (md == 2'b00) ? 1 : (md == 2'b01) ? 4 : 2;
        for (int j = 0; j < 256; j++) begin
            if (accm) e = (len * 3000) % 3329;
            else e = (fa(k, j) + ((md == 2'b10) ? fb(k, j) : 0)
                      + off) % 3329;
            if (pc[j*12 +: 12] !== 12'(e)) n++;
        end
        return n;
    endfunction

    task automatic do_run(input int u, input logic [1:0] md,
                          input int len, input logic ac,
                          input bit poke);
        int na, nb, ns, sbad, nv, vbad, pbad, nd, ne;
        int ba0, bb0, nbk, expst, ix, pk, bsd;
        bit accm;
        logic a, b, vl, dn, er, bs;
        logic [2:0] st;
        logic [PW-1:0] pc;
        nbk = u ? 64 : 256;
        accm = ac && ACC_ON;
        expst = (md == 2'b00) ? 1 : (md == 2'b01) ? 4 : 2;
        ba0 = nba[u];
        bb0 = nbb[u];
        na = 1; nb = 0; ns = 0; sbad = 0; nv = 0;
        vbad = 0; pbad = 0; nd = 0; ne = 0; pk = 0; bsd = 0;
        mode = md;
        vlen = 3'(len);
        acc = ac;
        if (u != 0) run4 = 1'b1;
        else run1 = 1'b1;
        @(negedge clk);
        run1 = 1'b0;
        run4 = 1'b0;
        chk("load_a_cycle1",
            u ? c4.core_load_a_o : c1.core_load_a_o, 1);
        for (int t = 0; t < 4000 + 8; t++) begin
            if (nd != 0 && t > 0) begin
                if (t >= 4000) break;
            end
            @(negedge clk);
            a  = u ? c4.core_load_a_o : c1.core_load_a_o;
            b  = u ? c4.core_load_b_o : c1.core_load_b_o;
            st = u ? c4.core_start_o : c1.core_start_o;
            vl = u ? valid4 : valid1;
            dn = u ? done4 : done1;
            er = u ? err4 : err1;
            bs = u ? busy4 : busy1;
            ix = u ? int'(idx4) : int'(idx1);
            pc = u ? pc4 : pc1;
            if (pk == 2) begin
                mode = 2'b11;
                if (u != 0) run4 = 1'b1;
                else run1 = 1'b1;
                pk = 1;
            end else if (pk == 1) begin
                mode = md;
                run1 = 1'b0;
                run4 = 1'b0;
                pk = 3;
            end
            na += int'(a);
            nb += int'(b);
            if (st != 0) begin
                ns++;
                if (int'(st) != expst) sbad++;
                if (poke && pk == 0) pk = 2;
            end
            if (vl) begin
                if (ix != (accm ? len - 1 : nv)) vbad++;
                pbad += poly_bad(pc, ix, md, accm, len);
                nv++;
            end
            if (er) ne++;
            if (dn) begin
                nd++;
                bsd += int'(bs);
                if (nd == 1) t = 3995;
            end
        end
        chk("n_load_a", na, len);
        chk("n_load_b", nb, (md == 2'b10) ? len : 0);
        chk("n_start", ns, len);
        chk("start_code_bad", sbad, 0);
        chk("a_beats", nba[u] - ba0, len * nbk);
        chk("b_beats", nbb[u] - bb0, (md == 2'b10) ? len * nbk : 0);
        chk("n_valid", nv, accm ? 1 : len);
        chk("valid_idx_bad", vbad, 0);
        chk("coef_bad", pbad, 0);
        chk("n_done", nd, 1);
        chk("n_err", ne, 0);
        chk("busy_at_done", bsd, 0);
        chk("busy_after", u ? busy4 : busy1, 0);
    endtask

    task automatic reject(input logic [1:0] md, input logic [2:0] len);
        mode = md;
        vlen = len;
        run4 = 1'b1;
        @(negedge clk);
        run4 = 1'b0;
        chk("rej_err", err4, 1);
        chk("rej_busy", busy4, 0);
        chk("rej_load", c4.core_load_a_o, 0);
        @(negedge clk);
        chk("rej_err_once", err4, 0);
        chk("rej_busy2", busy4, 0);
        chk("rej_load2", c4.core_load_a_o, 0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_busy", {busy1, busy4}, 0);
        chk("rst_pulses", {valid1, valid4, done1, done4,
            err1, err4, c1.core_load_a_o, c4.core_load_a_o}, 0);
        chk("rst_start", {c1.core_start_o, c4.core_start_o}, 0);
        chk("rst_polyc", 32'((pc1 == '0) && (pc4 == '0)), 1);
        chk("rst_idx", {idx1, idx4}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_run(0, 2'b00, 1, 1'b0, 1'b0);
        do_run(1, 2'b10, 3, 1'b0, 1'b0);

        reject(2'b11, 3'd2);
        reject(2'b00, 3'd0);
        reject(2'b00, 3'd5);

        do_run(1, 2'b00, 2, 1'b0, 1'b1);

        mode = 2'b00;
        vlen = 3'd1;
        run4 = 1'b1;
        @(negedge clk);
        run4 = 1'b0;
        chk("rst2_load_a", c4.core_load_a_o, 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2_busy", busy4, 0);
        chk("rst2_pulses", {valid4, done4, err4, c4.core_load_a_o,
            c4.core_load_b_o, c4.core_read_o}, 0);
        chk("rst2_start", c4.core_start_o, 0);
        chk("rst2_din", c4.core_din_o[31:0], 0);
        chk("rst2_polyc", 32'(pc4 == '0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        do_run(1, 2'b01, 2, 1'b0, 1'b0);

`ifdef ACC_EN
        acc_mode = 1'b1;
        do_run(1, 2'b00, 3, 1'b1, 1'b0);
        acc_mode = 1'b0;
`else
        do_run(1, 2'b10, 2, 1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
